// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled mid-bit sampling, single-entry output buffer
// with valid/ready handshake, frame-error and overrun pulses.
module uart_receiver #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TICK_W  = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;

   logic              sync_r;
   logic              rx_s;
   logic              rx_prev_r;
   logic [2:0]        state_r;
   logic [2:0]        state_nxt;
   logic [DIV_W-1:0]  div_cnt_r;
   logic [DIV_W-1:0]  div_cnt_nxt;
   logic [TICK_W-1:0] tick_cnt_r;
   logic [TICK_W-1:0] tick_cnt_nxt;
   logic [2:0]        bit_cnt_r;
   logic [2:0]        bit_cnt_nxt;
   logic [7:0]        shift_r;
   logic [7:0]        shift_nxt;
   logic              tick_s;
   logic              start_edge_s;
   logic              byte_done_s;
   logic              stop_bad_s;
   logic              load_s;
   logic              drop_s;
   logic              valid_nxt;

   assign tick_s       = (div_cnt_r == DIV_LAST);
   assign start_edge_s = rx_prev_r & ~rx_s;

   // Next-state logic for the frame FSM, sample divider and shift register
   always_comb begin
      state_nxt    = state_r;
      div_cnt_nxt  = tick_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
      tick_cnt_nxt = tick_cnt_r;
      bit_cnt_nxt  = bit_cnt_r;
      shift_nxt    = shift_r;
      byte_done_s  = 1'b0;
      stop_bad_s   = 1'b0;
      case (state_r)
         IDLE: begin
            tick_cnt_nxt = {TICK_W{1'b0}};
            if (start_edge_s) begin
               state_nxt   = START;
               div_cnt_nxt = {DIV_W{1'b0}};
            end else begin
               state_nxt = IDLE;
            end
         end
         START: begin
            if (tick_s && (tick_cnt_r == TICK_MID)) begin
               tick_cnt_nxt = {TICK_W{1'b0}};
               bit_cnt_nxt  = 3'd0;
               state_nxt    = rx_s ? IDLE : DATA;
            end else if (tick_s) begin
               tick_cnt_nxt = tick_cnt_r + TICK_W'(1);
            end else begin
               tick_cnt_nxt = tick_cnt_r;
            end
         end
         DATA: begin
            if (tick_s && (tick_cnt_r == TICK_LAST)) begin
               tick_cnt_nxt = {TICK_W{1'b0}};
               shift_nxt    = {rx_s, shift_r[7:1]};
               if (bit_cnt_r == 3'd7) begin
                  state_nxt = STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt_r + 3'd1;
               end
            end else if (tick_s) begin
               tick_cnt_nxt = tick_cnt_r + TICK_W'(1);
            end else begin
               tick_cnt_nxt = tick_cnt_r;
            end
         end
         STOP: begin
            // Going idle at mid-stop leaves half a bit to catch a back-to-back start edge
            if (tick_s && (tick_cnt_r == TICK_LAST)) begin
               tick_cnt_nxt = {TICK_W{1'b0}};
               if (rx_s) begin
                  byte_done_s = 1'b1;
                  state_nxt   = IDLE;
               end else begin
                  stop_bad_s = 1'b1;
                  state_nxt  = WAIT_HIGH;
               end
            end else if (tick_s) begin
               tick_cnt_nxt = tick_cnt_r + TICK_W'(1);
            end else begin
               tick_cnt_nxt = tick_cnt_r;
            end
         end
         WAIT_HIGH: begin
            if (rx_s) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WAIT_HIGH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output buffer: load when empty or being consumed, otherwise drop and flag overrun
   always_comb begin
      load_s = byte_done_s & (~rx_valid | rx_ready);
      drop_s = byte_done_s & rx_valid & ~rx_ready;
      if (load_s) begin
         valid_nxt = 1'b1;
      end else if (rx_valid && rx_ready) begin
         valid_nxt = 1'b0;
      end else begin
         valid_nxt = rx_valid;
      end
   end

   // Synchronizer, FSM and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r     <= 1'b1;
         rx_s       <= 1'b1;
         rx_prev_r  <= 1'b1;
         state_r    <= IDLE;
         div_cnt_r  <= {DIV_W{1'b0}};
         tick_cnt_r <= {TICK_W{1'b0}};
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
      end else begin
         sync_r     <= uart_rx;
         rx_s       <= sync_r;
         rx_prev_r  <= rx_s;
         state_r    <= state_nxt;
         div_cnt_r  <= div_cnt_nxt;
         tick_cnt_r <= tick_cnt_nxt;
         bit_cnt_r  <= bit_cnt_nxt;
         shift_r    <= shift_nxt;
      end
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_data   <= load_s ? shift_r : rx_data;
         rx_valid  <= valid_nxt;
         frame_err <= stop_bad_s;
         overrun   <= drop_s;
         busy      <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames plus randomized traffic,
// expectations produced by a buffer-level model of the receiver.
module tb_uart_receiver;

   localparam int BITC = 160;   // clocks per bit at 1.6 MHz / 10 kbaud

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       uart_rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard: kind 0 = byte presented, 1 = frame error, 2 = overrun
   int         exp_kind[$];
   logic [7:0] exp_data[$];

   // Reference model: one-entry buffer
   logic       mv = 1'b0;
   logic [7:0] md = 8'h00;

   logic prev_valid = 1'b0;
   logic prev_ready = 1'b0;

   uart_receiver #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
      .clk(clk), .reset(reset), .uart_rx(uart_rx), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic ready_at_done);
      if (!stop_ok) begin
         exp_kind.push_back(1); exp_data.push_back(8'h00);
      end else if (mv && !ready_at_done) begin
         exp_kind.push_back(2); exp_data.push_back(8'h00);
      end else begin
         exp_kind.push_back(0); exp_data.push_back(b);
         mv = 1'b1; md = b;
      end
   endtask

   task automatic got_event(input int kind, input logic [7:0] d);
      int k;
      logic [7:0] e;
      if (exp_kind.size() == 0) begin
         check("unexpected_event", 32'(kind), 32'hFF);
      end else begin
         k = exp_kind.pop_front();
         e = exp_data.pop_front();
         check("event_kind", 32'(kind), 32'(k));
         if (k == 0 && kind == 0) check("event_data", 32'(d), 32'(e));
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (frame_err) got_event(1, 8'h00);
         if (overrun) got_event(2, 8'h00);
         if (rx_valid && (!prev_valid || prev_ready)) got_event(0, rx_data);
         prev_valid = rx_valid;
         prev_ready = rx_ready;
      end
   end

   task automatic drive_bits(input logic v, input int n);
      uart_rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
      drive_bits(1'b0, BITC);
      for (int i = 0; i < 8; i++) drive_bits(b[i], BITC);
      if (stop_low_bits > 0) drive_bits(1'b0, stop_low_bits * BITC);
      drive_bits(1'b1, BITC);
   endtask

   task automatic pulse_ready();
      rx_ready = 1'b1;
      @(posedge clk); #1;
      rx_ready = 1'b0;
      mv = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
      check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
      check({tag, "_overrun"}, 32'(overrun), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int bad_cnt;
      logic [7:0] b;
      logic bad;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      drive_bits(1'b1, 20);

      // Single byte held until consumed
      model_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'hA5, 0);
      check("a5_valid", 32'(rx_valid), 32'h1);
      check("a5_data", 32'(rx_data), 32'hA5);
      drive_bits(1'b1, 100);
      check("a5_valid_held", 32'(rx_valid), 32'h1);
      pulse_ready();
      check("a5_valid_cleared", 32'(rx_valid), 32'h0);

      // Stop bit low for 3 bit-times: one frame error, busy until line high
      model_frame(8'h3C, 1'b0, 1'b0);
      drive_bits(1'b0, BITC);
      for (int i = 0; i < 8; i++) drive_bits(b_of(8'h3C, i), BITC);
      drive_bits(1'b0, 3 * BITC);
      check("break_busy_high", 32'(busy), 32'h1);
      drive_bits(1'b1, 5);
      check("break_busy_low", 32'(busy), 32'h0);
      drive_bits(1'b1, BITC);
      check("break_no_valid", 32'(rx_valid), 32'h0);

      // 50-clock glitch rejected
      cnt = 0;
      uart_rx = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (i == 49) uart_rx = 1'b1;
         if (busy) cnt++;
      end
      check("glitch_busy_window", 32'((cnt > 0) && (cnt < 100)), 32'h1);
      check("glitch_busy_low", 32'(busy), 32'h0);
      check("glitch_no_valid", 32'(rx_valid), 32'h0);

      // Back-to-back with no consume: second byte overruns
      model_frame(8'h11, 1'b1, 1'b0);
      model_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h11, 0);
      send_frame(8'h22, 0);
      check("ovr_data", 32'(rx_data), 32'(md));
      check("ovr_valid", 32'(rx_valid), 32'h1);
      pulse_ready();
      drive_bits(1'b1, 50);

      // Back-to-back with consume in the completion cycle of the second byte
      model_frame(8'h55, 1'b1, 1'b0);
      send_frame(8'h55, 0);
      model_frame(8'h66, 1'b1, 1'b1);
      fork
         send_frame(8'h66, 0);
         begin
            repeat (1522) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      check("reload_data", 32'(rx_data), 32'h66);
      check("reload_valid", 32'(rx_valid), 32'h1);
      pulse_ready();
      drive_bits(1'b1, 50);

      // Reset in the middle of bit 4 of 0xFF
      drive_bits(1'b0, BITC);
      for (int i = 0; i < 4; i++) drive_bits(1'b1, BITC);
      drive_bits(1'b1, BITC / 2);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midframe_reset");
      reset = 1'b0;
      mv = 1'b0;
      bad_cnt = 0;
      for (int i = 0; i < 20 * BITC; i++) begin
         @(posedge clk); #1;
         if (rx_valid || frame_err || overrun) bad_cnt++;
      end
      check("post_reset_quiet", 32'(bad_cnt), 32'h0);
      check("post_reset_busy", 32'(busy), 32'h0);

      // Randomized traffic
      for (int n = 0; n < 12; n++) begin
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 3) == 0);
         model_frame(b, !bad, 1'b0);
         send_frame(b, bad ? 1 : 0);
         if ($urandom_range(0, 2) != 0) begin
            drive_bits(1'b1, $urandom_range(20, 300));
            if ($urandom_range(0, 1) == 1) pulse_ready();
         end
      end
      drive_bits(1'b1, 200);
      check("final_valid", 32'(rx_valid), 32'(mv));
      if (mv) check("final_data", 32'(rx_data), 32'(md));
      check("scoreboard_empty", 32'(exp_kind.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   function automatic logic b_of(input logic [7:0] v, input int i);
      return v[i];
   endfunction

endmodule
